// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and branch condition encodings for the PC unit
// Purpose: branch_op encodings (identical to the RISC-V branch funct3 field)
//          and the default reset vector.
package pc_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_op_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/observation bundle between the core controller and pc_unit
// Purpose: groups the redirect controls, ALU flags, trap request and PC outputs.
// Ports (signals):
//   controller -> pc_unit : stall, pc_write, pc_write_cond, branch_op, zero,
//                           negative, overflow, carry, target, trap, trap_vector
//   pc_unit -> controller : pc, pc_plus_inc, pc_prev, branch_taken, misaligned,
//                           adv_count
// Modports: master = controller side, slave = pc_unit side.
interface pc_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic             stall;
  logic             pc_write;
  logic             pc_write_cond;
  logic [2:0]       branch_op;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             carry;
  logic [XLEN-1:0]  target;
  logic             trap;
  logic [XLEN-1:0]  trap_vector;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus_inc;
  logic [XLEN-1:0]  pc_prev;
  logic             branch_taken;
  logic             misaligned;
  logic [CNT_W-1:0] adv_count;

  modport master (
    output stall, pc_write, pc_write_cond, branch_op,
           zero, negative, overflow, carry, target, trap, trap_vector,
    input  pc, pc_plus_inc, pc_prev, branch_taken, misaligned, adv_count
  );

  modport slave (
    input  stall, pc_write, pc_write_cond, branch_op,
           zero, negative, overflow, carry, target, trap, trap_vector,
    output pc, pc_plus_inc, pc_prev, branch_taken, misaligned, adv_count
  );

endinterface

// File: rtl/pc_unit_branch_cond.sv
// rtl/pc_unit_branch_cond.sv - combinational branch condition evaluator from ALU flags
// Purpose: decides whether a conditional branch is taken, given the flags of
//          rs1-rs2. Shared with the pipelined core's EX-stage branch resolution.
// Ports:
//   i_branch_op  in  3  condition select (pc_pkg::branch_op_e)
//   i_zero       in  1  rs1 == rs2
//   i_negative   in  1  sign bit of rs1-rs2
//   i_overflow   in  1  signed overflow of rs1-rs2
//   i_carry      in  1  1 = no borrow (rs1 >= rs2 unsigned)
//   o_cond       out 1  condition holds
module branch_cond
  import pc_pkg::*;
(
  input  logic [2:0] i_branch_op,
  input  logic       i_zero,
  input  logic       i_negative,
  input  logic       i_overflow,
  input  logic       i_carry,
  output logic       o_cond
);

  // Signed less-than from a subtraction is sign XOR overflow.
  logic w_lt;
  assign w_lt = i_negative ^ i_overflow;

  always_comb begin
    o_cond = 1'b0;
    case (branch_op_e'(i_branch_op))
      BR_BEQ:  o_cond = i_zero;
      BR_BNE:  o_cond = ~i_zero;
      BR_BLT:  o_cond = w_lt;
      BR_BGE:  o_cond = ~w_lt;
      BR_BLTU: o_cond = ~i_carry;
      BR_BGEU: o_cond = i_carry;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - architectural program counter with branch/jump/trap next-PC selection
// Purpose: holds the PC and selects the next PC from trap, stall, misaligned
//          redirect, redirect or sequential increment (in that priority).
// Ports:
//   clk    in  1  core clock, rising edge
//   reset  in  1  synchronous active-high reset
//   bus    pc_unit_if.slave  controls, flags, targets and PC outputs
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              CNT_W        = 32
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_pc_prev;
  logic             r_branch_taken;
  logic             r_misaligned;
  logic [CNT_W-1:0] r_adv_count;

  logic             w_cond;
  logic             w_redirect;
  logic             w_mis;
  logic [XLEN-1:0]  w_pc_plus_inc;

  branch_cond u_branch_cond (
    .i_branch_op (bus.branch_op),
    .i_zero      (bus.zero),
    .i_negative  (bus.negative),
    .i_overflow  (bus.overflow),
    .i_carry     (bus.carry),
    .o_cond      (w_cond)
  );

  // pc_write alone forces the redirect, so pc_write together with
  // pc_write_cond is taken whatever the condition says.
  assign w_redirect = bus.pc_write | (bus.pc_write_cond & w_cond);

  generate
    if (ALIGN_BITS > 0) begin : g_align_check
      assign w_mis = w_redirect & (|bus.target[ALIGN_BITS-1:0]);
    end else begin : g_no_align_check
      assign w_mis = 1'b0;
    end
  endgenerate

  assign w_pc_plus_inc = r_pc + XLEN'(INC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= RESET_VECTOR;
      r_pc_prev      <= RESET_VECTOR;
      r_branch_taken <= 1'b0;
      r_misaligned   <= 1'b0;
      r_adv_count    <= '0;
    end else begin
      r_branch_taken <= 1'b0;
      r_misaligned   <= 1'b0;
      // Trap beats stall; a stalled cycle drops any redirect, so the
      // controller must keep presenting it until the stall clears.
      if (bus.trap) begin
        r_pc        <= bus.trap_vector;
        r_pc_prev   <= r_pc;
        r_adv_count <= r_adv_count + CNT_W'(1);
      end else if (!bus.stall) begin
        r_pc_prev   <= r_pc;
        r_adv_count <= r_adv_count + CNT_W'(1);
        if (w_mis) begin
          r_pc         <= bus.trap_vector;
          r_misaligned <= 1'b1;
        end else if (w_redirect) begin
          r_pc           <= bus.target;
          r_branch_taken <= 1'b1;
        end else begin
          r_pc <= w_pc_plus_inc;
        end
      end
    end
  end

  assign bus.pc           = r_pc;
  assign bus.pc_plus_inc  = w_pc_plus_inc;
  assign bus.pc_prev      = r_pc_prev;
  assign bus.branch_taken = r_branch_taken;
  assign bus.misaligned   = r_misaligned;
  assign bus.adv_count    = r_adv_count;

endmodule
